// File: rtl/nfc_apb_cmd.sv
// -----------------------------------------------------------------------------
// nfc_apb_cmd
//
// APB slave front end for the NAND flash FSM. Software programs the command
// bytes, a 5-byte address, a transfer length and an operation code, then
// writes START. The block streams CMD0, CMD1 and the address bytes to the FSM
// one per cycle, pulses C_Start, and waits for C_Done or a timeout. The result
// is reported in STATUS and, if enabled, on IRQ.
//
// Ports
//   P_clk, P_nrst        clock, asynchronous active-low reset
//   PSEL .. PWDATA       APB request (8-bit byte address, 32-bit data)
//   PRDATA, PREADY,      APB response; PREADY is tied high (no wait states)
//   PSLVERR
//   C_Cmd, C_CmdVld      command byte stream to the FSM, one pulse per byte
//   C_Addr, C_AddrVld    address byte stream to the FSM, one pulse per byte
//   C_Length             transfer length, stable while an operation runs
//   C_Op, C_Start        operation code and one-cycle launch pulse
//   C_Done, C_Status     completion pulse and status byte from the FSM
//   IRQ                  registered interrupt: IRQ_EN & (DONE | ERR)
//
// Register map (byte addresses)
//   0x00 CTRL    [0] START (write-1 pulse, reads 0), [2:1] OP, [8] IRQ_EN
//   0x04 CMD     [7:0] CMD0, [15:8] CMD1
//   0x08 ADDR_LO A3..A0, A0 in [7:0]
//   0x0C ADDR_HI [7:0] A4
//   0x10 LEN     [7:0]
//   0x14 STATUS  [0] BUSY, [1] DONE (W1C), [2] ERR (W1C), [15:8] last C_Status
// -----------------------------------------------------------------------------
module nfc_apb_cmd #(
    parameter int unsigned TIMEOUT_CYC = 65535,
    parameter int unsigned TO_W        = 16
) (
    input  logic        P_clk,
    input  logic        P_nrst,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [7:0]  PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic [7:0]  C_Cmd,
    output logic        C_CmdVld,
    output logic [7:0]  C_Addr,
    output logic        C_AddrVld,
    output logic [7:0]  C_Length,
    output logic [1:0]  C_Op,
    output logic        C_Start,
    input  logic        C_Done,
    input  logic [7:0]  C_Status,
    output logic        IRQ
);

    localparam logic [7:0] ADR_CTRL    = 8'h00;
    localparam logic [7:0] ADR_CMD     = 8'h04;
    localparam logic [7:0] ADR_ADDR_LO = 8'h08;
    localparam logic [7:0] ADR_ADDR_HI = 8'h0C;
    localparam logic [7:0] ADR_LEN     = 8'h10;
    localparam logic [7:0] ADR_STATUS  = 8'h14;

    localparam logic [1:0] OP_ERASE = 2'b11;

    // WAIT has run for TIMEOUT_CYC cycles when the counter (cleared on entry)
    // holds TIMEOUT_CYC-1 at a clock edge.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD0,
        S_CMD1,
        S_ADDR,
        S_LAUNCH,
        S_WAIT
    } state_e;

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    state_e            state_q;
    logic [1:0]        op_q;          // operation latched at START
    logic [2:0]        byte_cnt_q;    // address byte index
    logic [TO_W-1:0]   to_cnt_q;      // WAIT cycle counter

    logic [7:0]        cmd_out_q;
    logic              cmd_vld_q;
    logic [7:0]        addr_out_q;
    logic              addr_vld_q;
    logic              start_q;
    logic [1:0]        c_op_q;

    logic [1:0]        ctrl_op_q;
    logic              irq_en_q;
    logic [7:0]        cmd0_q;
    logic [7:0]        cmd1_q;
    logic [31:0]       addr_lo_q;
    logic [7:0]        addr_hi_q;
    logic [7:0]        len_q;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [7:0]        sts_q, sts_d;
    logic              irq_q;

    // ---------------------------------------------------------------------
    // APB decode
    // ---------------------------------------------------------------------
    logic access, wr_access, busy;
    logic sel_ctrl, sel_cmd, sel_alo, sel_ahi, sel_len, sel_stat;
    logic sel_cfg, mapped, cfg_we, status_we, start_req;
    logic done_set, err_set;
    logic [2:0] addr_last;

    assign access    = PSEL & PENABLE;
    assign wr_access = access & PWRITE;
    assign busy      = (state_q != S_IDLE);

    assign sel_ctrl = (PADDR == ADR_CTRL);
    assign sel_cmd  = (PADDR == ADR_CMD);
    assign sel_alo  = (PADDR == ADR_ADDR_LO);
    assign sel_ahi  = (PADDR == ADR_ADDR_HI);
    assign sel_len  = (PADDR == ADR_LEN);
    assign sel_stat = (PADDR == ADR_STATUS);
    assign sel_cfg  = sel_ctrl | sel_cmd | sel_alo | sel_ahi | sel_len;
    assign mapped   = sel_cfg | sel_stat;

    // Configuration registers are frozen while an operation is in flight;
    // STATUS stays writable so software can acknowledge at any time.
    assign cfg_we    = wr_access & sel_cfg & ~busy;
    assign status_we = wr_access & sel_stat;
    assign start_req = cfg_we & sel_ctrl & PWDATA[0] & (PWDATA[2:1] != 2'b00);

    assign PREADY  = 1'b1;
    assign PSLVERR = access & (~mapped | (PWRITE & busy & sel_cfg));

    // C_Done beats the timeout when both land on the same edge.
    assign done_set = (state_q == S_WAIT) & C_Done;
    assign err_set  = (state_q == S_WAIT) & ~C_Done & (to_cnt_q == TO_LAST);

    // Erase sends A0..A2 only; read/write send A0..A4.
    assign addr_last = (op_q == OP_ERASE) ? 3'd2 : 3'd4;

    function automatic logic [7:0] addr_byte(input logic [31:0] lo,
                                             input logic [7:0]  hi,
                                             input logic [2:0]  idx);
        case (idx)
            3'd0:    addr_byte = lo[7:0];
            3'd1:    addr_byte = lo[15:8];
            3'd2:    addr_byte = lo[23:16];
            3'd3:    addr_byte = lo[31:24];
            default: addr_byte = hi;
        endcase
    endfunction

    // ---------------------------------------------------------------------
    // Read mux
    // ---------------------------------------------------------------------
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned (which would infer a latch).
        PRDATA = '0;
        if (access) begin
            case (PADDR)
                ADR_CTRL:    PRDATA = {23'd0, irq_en_q, 5'd0, ctrl_op_q, 1'b0};
                ADR_CMD:     PRDATA = {16'd0, cmd1_q, cmd0_q};
                ADR_ADDR_LO: PRDATA = addr_lo_q;
                ADR_ADDR_HI: PRDATA = {24'd0, addr_hi_q};
                ADR_LEN:     PRDATA = {24'd0, len_q};
                ADR_STATUS:  PRDATA = {16'd0, sts_q, 5'd0, err_q, done_q, busy};
                default:     PRDATA = '0;
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // STATUS next state: a hardware set wins over a same-cycle W1C.
    // ---------------------------------------------------------------------
    always_comb begin
        done_d = (done_q & ~(status_we & PWDATA[1])) | done_set;
        err_d  = (err_q  & ~(status_we & PWDATA[2])) | err_set;
        sts_d  = done_set ? C_Status : sts_q;
    end

    // ---------------------------------------------------------------------
    // Register file
    // ---------------------------------------------------------------------
    always_ff @(posedge P_clk or negedge P_nrst) begin
        if (!P_nrst) begin
            ctrl_op_q <= '0;
            irq_en_q  <= 1'b0;
            cmd0_q    <= '0;
            cmd1_q    <= '0;
            addr_lo_q <= '0;
            addr_hi_q <= '0;
            len_q     <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            sts_q     <= '0;
            irq_q     <= 1'b0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // register samples pre-edge values, independent of block order.
            if (cfg_we && sel_ctrl) begin
                ctrl_op_q <= PWDATA[2:1];
                irq_en_q  <= PWDATA[8];
            end
            if (cfg_we && sel_cmd) begin
                cmd0_q <= PWDATA[7:0];
                cmd1_q <= PWDATA[15:8];
            end
            if (cfg_we && sel_alo) addr_lo_q <= PWDATA;
            if (cfg_we && sel_ahi) addr_hi_q <= PWDATA[7:0];
            if (cfg_we && sel_len) len_q     <= PWDATA[7:0];
            done_q <= done_d;
            err_q  <= err_d;
            sts_q  <= sts_d;
            // Built from the registered flags, so IRQ follows DONE/ERR by one cycle.
            irq_q  <= irq_en_q & (done_q | err_q);
        end
    end

    // ---------------------------------------------------------------------
    // Sequencer. Each state's byte/pulse is registered on the edge that
    // leaves the state, so START-edge to C_Start is 3+N cycles.
    // ---------------------------------------------------------------------
    always_ff @(posedge P_clk or negedge P_nrst) begin
        if (!P_nrst) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            byte_cnt_q <= '0;
            to_cnt_q   <= '0;
            cmd_out_q  <= '0;
            cmd_vld_q  <= 1'b0;
            addr_out_q <= '0;
            addr_vld_q <= 1'b0;
            start_q    <= 1'b0;
            c_op_q     <= '0;
        end else begin
            // Pulses and their data default low; states below raise them.
            cmd_out_q  <= '0;
            cmd_vld_q  <= 1'b0;
            addr_out_q <= '0;
            addr_vld_q <= 1'b0;
            start_q    <= 1'b0;
            c_op_q     <= '0;

            case (state_q)
                S_IDLE: begin
                    if (start_req) begin
                        op_q    <= PWDATA[2:1];
                        state_q <= S_CMD0;
                    end
                end
                S_CMD0: begin
                    cmd_out_q <= cmd0_q;
                    cmd_vld_q <= 1'b1;
                    state_q   <= S_CMD1;
                end
                S_CMD1: begin
                    cmd_out_q  <= cmd1_q;
                    cmd_vld_q  <= 1'b1;
                    byte_cnt_q <= '0;
                    state_q    <= S_ADDR;
                end
                S_ADDR: begin
                    addr_out_q <= addr_byte(addr_lo_q, addr_hi_q, byte_cnt_q);
                    addr_vld_q <= 1'b1;
                    if (byte_cnt_q == addr_last) begin
                        state_q <= S_LAUNCH;
                    end else begin
                        byte_cnt_q <= byte_cnt_q + 3'd1;
                    end
                end
                S_LAUNCH: begin
                    start_q  <= 1'b1;
                    c_op_q   <= op_q;
                    to_cnt_q <= '0;
                    state_q  <= S_WAIT;
                end
                S_WAIT: begin
                    if (C_Done || (to_cnt_q == TO_LAST)) begin
                        state_q <= S_IDLE;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign C_Cmd     = cmd_out_q;
    assign C_CmdVld  = cmd_vld_q;
    assign C_Addr    = addr_out_q;
    assign C_AddrVld = addr_vld_q;
    assign C_Start   = start_q;
    assign C_Op      = c_op_q;
    // LEN cannot be written while busy, so it is stable through LAUNCH..WAIT.
    assign C_Length  = len_q;
    assign IRQ       = irq_q;

endmodule

// File: tb/tb_nfc_apb_cmd.sv
// -----------------------------------------------------------------------------
// tb_nfc_apb_cmd
//
// Scoreboard bench for nfc_apb_cmd. Stimulus tasks update a register-level
// model of the block and push the expected APB responses, command bytes,
// address bytes and launch events into queues; an independent monitor pops
// and compares whenever the DUT presents an access phase or a valid pulse.
// -----------------------------------------------------------------------------
module tb_nfc_apb_cmd;

    localparam int TO = 8;

    logic        P_clk   = 1'b0;
    logic        P_nrst  = 1'b0;
    logic        PSEL    = 1'b0;
    logic        PENABLE = 1'b0;
    logic        PWRITE  = 1'b0;
    logic [7:0]  PADDR   = '0;
    logic [31:0] PWDATA  = '0;
    logic        C_Done  = 1'b0;
    logic [7:0]  C_Status = '0;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR;
    logic [7:0]  C_Cmd, C_Addr, C_Length;
    logic        C_CmdVld, C_AddrVld, C_Start, IRQ;
    logic [1:0]  C_Op;

    nfc_apb_cmd #(.TIMEOUT_CYC(TO), .TO_W(16)) dut (
        .P_clk(P_clk), .P_nrst(P_nrst),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .C_Cmd(C_Cmd), .C_CmdVld(C_CmdVld), .C_Addr(C_Addr), .C_AddrVld(C_AddrVld),
        .C_Length(C_Length), .C_Op(C_Op), .C_Start(C_Start),
        .C_Done(C_Done), .C_Status(C_Status), .IRQ(IRQ)
    );

    always #5 P_clk = ~P_clk;

    int cyc = 0;
    always @(posedge P_clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------------------------------------------------------------
    // Scoreboard queues
    // ---------------------------------------------------------------------
    typedef struct {
        logic        wr;
        logic [31:0] rdata;
        logic        slverr;
    } apb_exp_t;

    typedef struct {
        logic [7:0] val;
        int         cyc;
    } byte_exp_t;

    typedef struct {
        logic [1:0] op;
        logic [7:0] len;
        int         cyc;
    } start_exp_t;

    apb_exp_t   apb_q[$];
    byte_exp_t  cmd_q[$];
    byte_exp_t  addr_q[$];
    start_exp_t start_q[$];
    int         exp_starts  = 0;
    int         seen_starts = 0;
    int         start_cyc   = 0;

    // ---------------------------------------------------------------------
    // Reference model: software-visible register state
    // ---------------------------------------------------------------------
    logic [1:0] m_op;
    logic       m_irq_en;
    logic [7:0] m_cmd0, m_cmd1, m_len, m_stat;
    logic [7:0] m_a [5];
    logic       m_busy, m_done, m_err;

    task automatic model_reset();
        m_op = '0; m_irq_en = 0; m_cmd0 = '0; m_cmd1 = '0; m_len = '0; m_stat = '0;
        for (int i = 0; i < 5; i++) m_a[i] = '0;
        m_busy = 0; m_done = 0; m_err = 0;
    endtask

    function automatic logic [31:0] model_read(input logic [7:0] a);
        case (a)
            8'h00:   return {23'd0, m_irq_en, 5'd0, m_op, 1'b0};
            8'h04:   return {16'd0, m_cmd1, m_cmd0};
            8'h08:   return {m_a[3], m_a[2], m_a[1], m_a[0]};
            8'h0C:   return {24'd0, m_a[4]};
            8'h10:   return {24'd0, m_len};
            8'h14:   return {16'd0, m_stat, 5'd0, m_err, m_done, m_busy};
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic model_err(input logic wr, input logic [7:0] a);
        logic mapped;
        mapped = (a == 8'h00) || (a == 8'h04) || (a == 8'h08) ||
                 (a == 8'h0C) || (a == 8'h10) || (a == 8'h14);
        return !mapped || (wr && m_busy && (a != 8'h14));
    endfunction

    // Operation launch: the command/address stream and launch pulse follow
    // the START commit edge by fixed offsets.
    task automatic model_launch(input int commit);
        int n;
        n = (m_op == 2'b11) ? 3 : 5;
        m_busy = 1;
        cmd_q.push_back('{val: m_cmd0, cyc: commit + 1});
        cmd_q.push_back('{val: m_cmd1, cyc: commit + 2});
        for (int i = 0; i < n; i++) addr_q.push_back('{val: m_a[i], cyc: commit + 3 + i});
        start_q.push_back('{op: m_op, len: m_len, cyc: commit + 3 + n});
        exp_starts++;
    endtask

    task automatic model_write(input logic [7:0] a, input logic [31:0] d, input int commit);
        if (model_err(1'b1, a)) return;
        case (a)
            8'h00: begin
                m_op = d[2:1]; m_irq_en = d[8];
                if (d[0] && d[2:1] != 2'b00) model_launch(commit);
            end
            8'h04: begin m_cmd0 = d[7:0]; m_cmd1 = d[15:8]; end
            8'h08: begin m_a[0] = d[7:0]; m_a[1] = d[15:8]; m_a[2] = d[23:16]; m_a[3] = d[31:24]; end
            8'h0C: m_a[4] = d[7:0];
            8'h10: m_len = d[7:0];
            8'h14: begin
                if (d[1]) m_done = 0;
                if (d[2]) m_err = 0;
            end
            default: ;
        endcase
    endtask

    // ---------------------------------------------------------------------
    // Stimulus tasks (called #1 after a rising edge)
    // ---------------------------------------------------------------------
    task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
        apb_q.push_back('{wr: 1'b1, rdata: 32'd0, slverr: model_err(1'b1, a)});
        PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = a; PWDATA = d;
        @(posedge P_clk); #1; PENABLE = 1;
        @(posedge P_clk); #1; PSEL = 0; PENABLE = 0; PWRITE = 0;
        model_write(a, d, cyc);
    endtask

    task automatic apb_read(input logic [7:0] a);
        apb_q.push_back('{wr: 1'b0, rdata: model_read(a), slverr: model_err(1'b0, a)});
        PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = a;
        @(posedge P_clk); #1; PENABLE = 1;
        @(posedge P_clk); #1; PSEL = 0; PENABLE = 0;
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) begin @(posedge P_clk); #1; end
    endtask

    task automatic wait_start(output int s);
        int i = 0;
        while (seen_starts != exp_starts && i < 40) begin @(posedge P_clk); #1; i++; end
        check("start_seen", 32'(seen_starts), 32'(exp_starts));
        s = start_cyc;
    endtask

    task automatic do_done(input logic [7:0] st);
        C_Done = 1; C_Status = st;
        @(posedge P_clk); #1;
        C_Done = 0; C_Status = '0;
        if (m_busy) begin m_busy = 0; m_done = 1; m_stat = st; end
    endtask

    task automatic check_quiet_outputs(input string tag);
        check({tag, "_cmd"},     32'(C_Cmd),     32'd0);
        check({tag, "_cmdvld"},  32'(C_CmdVld),  32'd0);
        check({tag, "_addr"},    32'(C_Addr),    32'd0);
        check({tag, "_addrvld"}, 32'(C_AddrVld), 32'd0);
        check({tag, "_length"},  32'(C_Length),  32'd0);
        check({tag, "_op"},      32'(C_Op),      32'd0);
        check({tag, "_start"},   32'(C_Start),   32'd0);
        check({tag, "_irq"},     32'(IRQ),       32'd0);
        check({tag, "_prdata"},  PRDATA,         32'd0);
        check({tag, "_pslverr"}, 32'(PSLVERR),   32'd0);
        check({tag, "_pready"},  32'(PREADY),    32'd1);
    endtask

    // ---------------------------------------------------------------------
    // Monitor
    // ---------------------------------------------------------------------
    apb_exp_t   mon_a;
    byte_exp_t  mon_b;
    start_exp_t mon_s;

    always @(negedge P_clk) begin
        if (P_nrst) begin
            if (PSEL && PENABLE) begin
                if (apb_q.size() == 0) check("apb_unexpected", 32'(apb_q.size()), 32'd1);
                else begin
                    mon_a = apb_q.pop_front();
                    check("pslverr", 32'(PSLVERR), 32'(mon_a.slverr));
                    if (!mon_a.wr) check("prdata", PRDATA, mon_a.rdata);
                end
            end
            if (C_CmdVld) begin
                if (cmd_q.size() == 0) check("cmd_unexpected", 32'(cmd_q.size()), 32'd1);
                else begin
                    mon_b = cmd_q.pop_front();
                    check("cmd_byte", 32'(C_Cmd), 32'(mon_b.val));
                    check("cmd_cycle", 32'(cyc), 32'(mon_b.cyc));
                end
            end else check("cmd_idle_zero", 32'(C_Cmd), 32'd0);
            if (C_AddrVld) begin
                if (addr_q.size() == 0) check("addr_unexpected", 32'(addr_q.size()), 32'd1);
                else begin
                    mon_b = addr_q.pop_front();
                    check("addr_byte", 32'(C_Addr), 32'(mon_b.val));
                    check("addr_cycle", 32'(cyc), 32'(mon_b.cyc));
                end
            end else check("addr_idle_zero", 32'(C_Addr), 32'd0);
            if (C_Start) begin
                if (start_q.size() == 0) check("start_unexpected", 32'(start_q.size()), 32'd1);
                else begin
                    mon_s = start_q.pop_front();
                    check("start_op", 32'(C_Op), 32'(mon_s.op));
                    check("start_len", 32'(C_Length), 32'(mon_s.len));
                    check("start_cycle", 32'(cyc), 32'(mon_s.cyc));
                end
                seen_starts++;
                start_cyc = cyc;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------------
    // Test sequence
    // ---------------------------------------------------------------------
    initial begin
        int s, c, d;
        logic [7:0]  st, ra;
        logic [1:0]  rop;
        logic        rirq;

        model_reset();
        #2;
        check_quiet_outputs("por");
        repeat (3) @(posedge P_clk);
        #1; P_nrst = 1;
        apb_read(8'h14);
        apb_read(8'h00);

        // Read op
        apb_write(8'h04, 32'h0000_3000);
        apb_write(8'h08, 32'h0403_0201);
        apb_write(8'h0C, 32'h0000_0005);
        apb_write(8'h10, 32'h0000_0010);
        apb_read(8'h08);
        apb_write(8'h00, 32'h0000_0003);
        wait_start(s);
        do_done(8'h5A);
        apb_read(8'h14);
        apb_write(8'h14, 32'h2);
        apb_read(8'h14);

        // Erase op: three address bytes, launch 6 cycles after START
        apb_write(8'h04, 32'h0000_D060);
        apb_write(8'h00, 32'h0000_0007);
        wait_start(s);
        do_done(8'hC0);
        apb_read(8'h14);
        apb_write(8'h14, 32'h2);
        apb_read(8'h14);

        // Busy protection during WAIT
        apb_write(8'h00, 32'h0000_0003);
        wait_start(s);
        apb_write(8'h10, 32'h0000_0077);
        apb_read(8'h20);
        check("len_held", 32'(C_Length), 32'(m_len));
        do_done(8'h11);
        apb_read(8'h10);
        apb_write(8'h14, 32'h2);

        // Timeout with IRQ enabled
        apb_write(8'h00, 32'h0000_0103);
        wait_start(s);
        wait_until(s + TO - 2);
        apb_read(8'h14);
        m_busy = 0; m_err = 1;
        check("irq_before_rise", 32'(IRQ), 32'd0);
        @(posedge P_clk); #1;
        check("irq_rise", 32'(IRQ), 32'd1);
        apb_read(8'h14);
        apb_write(8'h14, 32'h4);
        check("irq_hold_at_w1c", 32'(IRQ), 32'd1);
        @(posedge P_clk); #1;
        check("irq_fall", 32'(IRQ), 32'd0);
        apb_read(8'h14);

        // Collision: C_Done on the timeout edge, W1C DONE on the same edge
        apb_write(8'h00, 32'h0000_0003);
        wait_start(s);
        wait_until(s + TO - 2);
        fork
            apb_write(8'h14, 32'h2);
            begin
                @(posedge P_clk); #1;
                C_Done = 1; C_Status = 8'hA5;
                @(posedge P_clk); #1;
                C_Done = 0; C_Status = '0;
            end
        join
        m_busy = 0; m_done = 1; m_err = 0; m_stat = 8'hA5;
        apb_read(8'h14);

        // START with OP=00 is ignored; C_Done outside WAIT is ignored
        apb_write(8'h00, 32'h0000_0001);
        apb_read(8'h00);
        do_done(8'h33);
        apb_read(8'h14);
        apb_write(8'h14, 32'h6);
        apb_read(8'h14);

        // Unmapped / misaligned addresses
        apb_write(8'h18, 32'hFFFF_FFFF);
        apb_read(8'h18);
        apb_read(8'h05);
        for (int i = 0; i < 4; i++) apb_read(8'($urandom));

        // Randomised operations
        for (int it = 0; it < 8; it++) begin
            apb_write(8'h04, $urandom);
            apb_write(8'h08, $urandom);
            apb_write(8'h0C, $urandom);
            apb_write(8'h10, $urandom);
            ra = 8'(4 * $urandom_range(0, 4));
            apb_read(ra);
            rop  = 2'($urandom_range(1, 3));
            rirq = 1'($urandom_range(0, 1));
            apb_write(8'h00, {23'd0, rirq, 5'd0, rop, 1'b1});
            apb_read(8'h14);
            wait_start(s);
            d = $urandom_range(0, 5);
            repeat (d) begin @(posedge P_clk); #1; end
            st = 8'($urandom);
            do_done(st);
            check("irq_rand_pre", 32'(IRQ), 32'd0);
            @(posedge P_clk); #1;
            check("irq_rand", 32'(IRQ), 32'(m_irq_en));
            apb_read(8'h14);
            apb_write(8'h14, 32'h2);
            @(posedge P_clk); #1;
            check("irq_rand_clear", 32'(IRQ), 32'd0);
        end

        // Reset in the middle of the address phase
        apb_write(8'h00, 32'h0000_0003);
        c = cyc;
        wait_until(c + 4);
        P_nrst = 0;
        #1;
        check_quiet_outputs("rst");
        cmd_q.delete(); addr_q.delete(); start_q.delete();
        exp_starts = seen_starts;
        model_reset();
        repeat (2) @(posedge P_clk);
        #1; P_nrst = 1;
        apb_read(8'h14);
        apb_read(8'h04);
        apb_read(8'h10);
        repeat (12) begin @(posedge P_clk); #1; end

        check("leftover_expectations",
              32'(apb_q.size() + cmd_q.size() + addr_q.size() + start_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
